// File: rtl/avalon_mem_arbiter_pkg.sv
// Shared types for the two-to-one Avalon-MM memory arbiter.
//   arb_state_e : grant state machine encoding
//   arb_tag_e   : read-tag value identifying which requester issued a read
package MemArbPkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        TAG_I = 1'b0,
        TAG_D = 1'b1
    } arb_tag_e;

endpackage

// File: rtl/avalon_mem_arbiter_tag_fifo.sv
// arb_tag_fifo: synchronous FIFO of 1-bit read tags.
// Ports:
//   clk, rst (async active-low)
//   push, push_tag : enqueue a tag
//   pop            : dequeue the head tag
//   full, empty    : occupancy flags from the registered count
//   head           : tag at the read pointer
//   count          : number of stored tags
// Push and pop may coincide at any occupancy, including full.
module arb_tag_fifo
    import MemArbPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  arb_tag_e                 push_tag,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output arb_tag_e                 head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    arb_tag_e           tag_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = tag_mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr_reg] <= push_tag;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: round-robin two-to-one Avalon-MM arbiter sharing one
// memory port between the instruction manager (read-only) and the data
// manager (read/write).
// Ports:
//   clk, rst (async active-low)
//   i_*  : instruction manager (address, read / waitrequest, readdata, readdatavalid)
//   d_*  : data manager (address, read, write, writedata, byteenable / responses)
//   m_*  : shared memory command out, response in
//   err_unexpected_rdv : sticky, readdatavalid seen with no outstanding read
module avalon_mem_arbiter
    import MemArbPkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_unexpected_rdv
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e         state_reg, state_next;
    arb_tag_e           last_grant_reg, last_grant_next;
    logic               err_reg;
    logic               i_eligible, d_eligible;
    logic               accept;
    logic               fifo_full, fifo_empty;
    arb_tag_e           fifo_head;
    arb_tag_e           push_tag;
    logic [CNT_W-1:0]   fifo_count;
    logic               unused_fifo_count;

    // Occupancy is kept for debug visibility only.
    assign unused_fifo_count = ^fifo_count;

    // Writes need no tag slot, so a full FIFO never blocks them.
    assign i_eligible = i_read && !fifo_full;
    assign d_eligible = d_write || (d_read && !fifo_full);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (i_eligible && (!d_eligible || last_grant_reg == TAG_D)) begin
                    state_next      = GRANT_I;
                    last_grant_next = TAG_I;
                end else if (d_eligible) begin
                    state_next      = GRANT_D;
                    last_grant_next = TAG_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!m_waitrequest) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= TAG_D;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (m_readdatavalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Command mux: the granted requester drives the memory port directly.
    always_comb begin
        m_address    = '0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_writedata  = '0;
        m_byteenable = '0;
        case (state_reg)
            GRANT_I: begin
                m_address    = i_address;
                m_read       = i_read;
                m_byteenable = '1;
            end
            GRANT_D: begin
                m_address    = d_address;
                m_read       = d_read;
                m_write      = d_write;
                m_writedata  = d_writedata;
                m_byteenable = d_byteenable;
            end
            default: ;
        endcase
    end

    assign accept        = (state_reg != IDLE) && !m_waitrequest;
    assign i_waitrequest = !(state_reg == GRANT_I && !m_waitrequest);
    assign d_waitrequest = !(state_reg == GRANT_D && !m_waitrequest);
    assign push_tag      = (state_reg == GRANT_D) ? TAG_D : TAG_I;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept && m_read),
        .push_tag (push_tag),
        .pop      (m_readdatavalid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // Responses are routed with zero latency; a beat with no tag is dropped.
    assign i_readdata         = m_readdata;
    assign d_readdata         = m_readdata;
    assign i_readdatavalid    = m_readdatavalid && !fifo_empty && (fifo_head == TAG_I);
    assign d_readdatavalid    = m_readdatavalid && !fifo_empty && (fifo_head == TAG_D);
    assign err_unexpected_rdv = err_reg;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
module tb_avalon_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        i_readdatavalid;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        d_readdatavalid;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        err_unexpected_rdv;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .i_address          (i_address),
        .i_read             (i_read),
        .i_waitrequest      (i_waitrequest),
        .i_readdata         (i_readdata),
        .i_readdatavalid    (i_readdatavalid),
        .d_address          (d_address),
        .d_read             (d_read),
        .d_write            (d_write),
        .d_writedata        (d_writedata),
        .d_byteenable       (d_byteenable),
        .d_waitrequest      (d_waitrequest),
        .d_readdata         (d_readdata),
        .d_readdatavalid    (d_readdatavalid),
        .m_address          (m_address),
        .m_read             (m_read),
        .m_write            (m_write),
        .m_writedata        (m_writedata),
        .m_byteenable       (m_byteenable),
        .m_waitrequest      (m_waitrequest),
        .m_readdata         (m_readdata),
        .m_readdatavalid    (m_readdatavalid),
        .err_unexpected_rdv (err_unexpected_rdv)
    );

    task automatic check_val(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, actual);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_writedata = '0; d_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

        // Reset state
        next_cycle(); next_cycle();
        mid_cycle();
        check_val("rst_i_wait", i_waitrequest, 1);
        check_val("rst_d_wait", d_waitrequest, 1);
        check_val("rst_m_read", m_read, 0);
        check_val("rst_m_write", m_write, 0);
        check_val("rst_err", err_unexpected_rdv, 0);
        check_val("rst_i_rdv", i_readdatavalid, 0);
        check_val("rst_d_rdv", d_readdatavalid, 0);
        next_cycle();
        rst = 1'b1;

        // Single instruction read, response 3 cycles after acceptance
        i_read = 1'b1; i_address = 32'h10;
        mid_cycle();
        check_val("t2_idle_m_read", m_read, 0);
        check_val("t2_idle_i_wait", i_waitrequest, 1);
        next_cycle();
        mid_cycle();
        check_val("t2_m_address", m_address, 32'h10);
        check_val("t2_m_read", m_read, 1);
        check_val("t2_m_be", m_byteenable, 4'hF);
        check_val("t2_i_wait", i_waitrequest, 0);
        check_val("t2_d_wait", d_waitrequest, 1);
        next_cycle();
        i_read = 1'b0;
        next_cycle(); next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
        mid_cycle();
        check_val("t2_i_rdv", i_readdatavalid, 1);
        check_val("t2_i_rdata", i_readdata, 32'hDEADBEEF);
        check_val("t2_d_rdv", d_readdatavalid, 0);
        next_cycle();
        m_readdatavalid = 1'b0;
        mid_cycle();
        check_val("t2_err", err_unexpected_rdv, 0);

        // Reset asserted while a data write is stalled in its grant
        next_cycle();
        d_write = 1'b1; d_address = 32'h40; d_writedata = 32'h1234; d_byteenable = 4'h3;
        m_waitrequest = 1'b1;
        next_cycle();
        mid_cycle();
        check_val("rg_m_write", m_write, 1);
        check_val("rg_m_be", m_byteenable, 4'h3);
        rst = 1'b0;
        #1;
        check_val("rg_rst_m_write", m_write, 0);
        check_val("rg_rst_d_wait", d_waitrequest, 1);
        d_write = 1'b0; m_waitrequest = 1'b0;
        next_cycle();
        rst = 1'b1;
        mid_cycle();
        check_val("rg_idle_m_write", m_write, 0);
        check_val("rg_fifo_count", dut.fifo_count, 0);

        // Both managers reading continuously: I, D, I, D
        next_cycle();
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        for (int k = 0; k < 4; k++) begin
            mid_cycle();
            check_val($sformatf("t3_idle%0d_m_read", k), m_read, 0);
            next_cycle();
            mid_cycle();
            check_val($sformatf("t3_g%0d_addr", k), m_address, (k % 2 == 0) ? 32'h100 : 32'h200);
            check_val($sformatf("t3_g%0d_i_wait", k), i_waitrequest, (k % 2 == 0) ? 0 : 1);
            check_val($sformatf("t3_g%0d_d_wait", k), d_waitrequest, (k % 2 == 0) ? 1 : 0);
            next_cycle();
        end
        i_read = 1'b0; d_read = 1'b0;
        mid_cycle();
        check_val("t3_fifo_count", dut.fifo_count, 4);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'(k + 1);
            mid_cycle();
            check_val($sformatf("t3_r%0d_i_rdv", k), i_readdatavalid, (k % 2 == 0) ? 1 : 0);
            check_val($sformatf("t3_r%0d_d_rdv", k), d_readdatavalid, (k % 2 == 0) ? 0 : 1);
            check_val($sformatf("t3_r%0d_data", k), (k % 2 == 0) ? i_readdata : d_readdata, k + 1);
            next_cycle();
        end
        m_readdatavalid = 1'b0;

        // Data write held off by waitrequest for 3 cycles
        d_write = 1'b1; d_address = 32'h20; d_writedata = 32'h55; d_byteenable = 4'hF;
        m_waitrequest = 1'b1;
        mid_cycle();
        check_val("t4_idle_m_write", m_write, 0);
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            if (j == 3) m_waitrequest = 1'b0;
            mid_cycle();
            check_val($sformatf("t4_c%0d_m_write", j), m_write, 1);
            check_val($sformatf("t4_c%0d_addr", j), m_address, 32'h20);
            check_val($sformatf("t4_c%0d_wdata", j), m_writedata, 32'h55);
            check_val($sformatf("t4_c%0d_d_wait", j), d_waitrequest, (j == 3) ? 0 : 1);
            next_cycle();
        end
        d_write = 1'b0;
        mid_cycle();
        check_val("t4_m_write_done", m_write, 0);
        check_val("t4_fifo_count", dut.fifo_count, 0);

        // Fill the tag FIFO with instruction reads
        next_cycle();
        i_read = 1'b1; i_address = 32'h300;
        for (int k = 0; k < 4; k++) begin
            mid_cycle();
            check_val($sformatf("t5_idle%0d_i_wait", k), i_waitrequest, 1);
            next_cycle();
            mid_cycle();
            check_val($sformatf("t5_g%0d_m_read", k), m_read, 1);
            check_val($sformatf("t5_g%0d_i_wait", k), i_waitrequest, 0);
            next_cycle();
        end
        d_write = 1'b1; d_address = 32'h30; d_writedata = 32'hAA;
        mid_cycle();
        check_val("t5_full_count", dut.fifo_count, 4);
        check_val("t5_full_m_read", m_read, 0);
        next_cycle();
        mid_cycle();
        check_val("t5_dw_m_write", m_write, 1);
        check_val("t5_dw_m_read", m_read, 0);
        check_val("t5_dw_d_wait", d_waitrequest, 0);
        check_val("t5_dw_i_wait", i_waitrequest, 1);
        next_cycle();
        d_write = 1'b0;
        mid_cycle();
        check_val("t5_stall_m_read", m_read, 0);
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 32'h77;
        mid_cycle();
        check_val("t5_pop_i_rdv", i_readdatavalid, 1);
        check_val("t5_pop_m_read", m_read, 0);
        next_cycle();
        m_readdatavalid = 1'b0;
        mid_cycle();
        check_val("t5_freed_count", dut.fifo_count, 3);
        check_val("t5_freed_m_read", m_read, 0);
        next_cycle();
        mid_cycle();
        check_val("t5_fifth_m_read", m_read, 1);
        check_val("t5_fifth_i_wait", i_waitrequest, 0);
        next_cycle();
        i_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'(16 + k);
            mid_cycle();
            check_val($sformatf("t5_drain%0d_i_rdv", k), i_readdatavalid, 1);
            next_cycle();
        end
        m_readdatavalid = 1'b0;
        mid_cycle();
        check_val("t5_drained_count", dut.fifo_count, 0);

        // Unexpected readdatavalid with the FIFO empty
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 32'h99;
        mid_cycle();
        check_val("t6_i_rdv", i_readdatavalid, 0);
        check_val("t6_d_rdv", d_readdatavalid, 0);
        next_cycle();
        m_readdatavalid = 1'b0;
        mid_cycle();
        check_val("t6_err_set", err_unexpected_rdv, 1);
        next_cycle(); next_cycle(); next_cycle();
        mid_cycle();
        check_val("t6_err_sticky", err_unexpected_rdv, 1);
        rst = 1'b0;
        #1;
        check_val("t6_err_cleared", err_unexpected_rdv, 0);
        next_cycle();
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
